// File: rtl/boot_loader.sv
// Streams IMEM_LENGTH instruction words then DMEM_LENGTH data words into the SRAMs,
// then releases the core and hands the SRAM ports back to the wrappers.
module boot_loader #(
   parameter int unsigned IMEM_LENGTH = 79,
   parameter int unsigned DMEM_LENGTH = 12
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        src_valid,
   input  logic [31:0] src_data,
   output logic        src_ready,
   input  logic        restart,
   input  logic        i_csb,
   input  logic        i_web,
   input  logic [9:0]  i_addr,
   input  logic [31:0] i_din,
   input  logic        d_csb,
   input  logic        d_web,
   input  logic [9:0]  d_addr,
   input  logic [31:0] d_din,
   output logic        instr_csb0,
   output logic        instr_web0,
   output logic [9:0]  instr_addr0,
   output logic [31:0] instr_din0,
   output logic        data_csb0,
   output logic        data_web0,
   output logic [9:0]  data_addr0,
   output logic [31:0] data_din0,
   output logic        core_RSTn,
   output logic        done,
   output logic [31:0] chksum
);

   localparam logic [9:0] ImemLast = 10'(IMEM_LENGTH - 1);
   localparam logic [9:0] DmemLast = 10'(DMEM_LENGTH - 1);

   typedef enum logic [1:0] {StLoadI, StLoadD, StDone} state_e;

   state_e      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [31:0] chksum_q, chksum_d;
   logic        ready_q;
   logic        done_q;
   logic        accept;

   assign src_ready = ready_q;
   assign core_RSTn = done_q;
   assign done      = done_q;
   assign chksum    = chksum_q;
   assign accept    = src_valid & ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      chksum_d    = chksum_q;
      instr_csb0  = 1'b1;
      instr_web0  = 1'b1;
      instr_addr0 = cnt_q;
      instr_din0  = src_data;
      data_csb0   = 1'b1;
      data_web0   = 1'b1;
      data_addr0  = cnt_q;
      data_din0   = src_data;
      case (state_q)
         StLoadI: begin
            if (accept) begin
               instr_csb0 = 1'b0;
               instr_web0 = 1'b0;
               chksum_d   = chksum_q + src_data;
               if (cnt_q == ImemLast) begin
                  cnt_d   = '0;
                  state_d = StLoadD;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
         end
         StLoadD: begin
            if (accept) begin
               data_csb0 = 1'b0;
               data_web0 = 1'b0;
               chksum_d  = chksum_q + src_data;
               if (cnt_q == DmemLast) begin
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
         end
         StDone: begin
            instr_csb0  = i_csb;
            instr_web0  = i_web;
            instr_addr0 = i_addr;
            instr_din0  = i_din;
            data_csb0   = d_csb;
            data_web0   = d_web;
            data_addr0  = d_addr;
            data_din0   = d_din;
            if (restart) begin
               state_d  = StLoadI;
               cnt_d    = '0;
               chksum_d = '0;
            end
         end
         default: state_d = StLoadI;
      endcase
   end

   // ready and done are registered copies of the next state, so neither depends on the stream.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= StLoadI;
         cnt_q    <= '0;
         chksum_q <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         chksum_q <= chksum_d;
         ready_q  <= (state_d != StDone);
         done_q   <= (state_d == StDone);
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: a word-count reference model predicts every SRAM write,
// handshake, checksum and release, and shadow SRAMs are compared after each complete load.
module tb_boot_loader;

   localparam int unsigned Imem  = 79;
   localparam int unsigned Dmem  = 12;
   localparam int unsigned Total = Imem + Dmem;

   logic        CLK, RSTn;
   logic        src_valid, src_ready, restart;
   logic [31:0] src_data;
   logic        i_csb, i_web, d_csb, d_web;
   logic [9:0]  i_addr, d_addr;
   logic [31:0] i_din, d_din;
   logic        instr_csb0, instr_web0, data_csb0, data_web0;
   logic [9:0]  instr_addr0, data_addr0;
   logic [31:0] instr_din0, data_din0;
   logic        core_RSTn, done;
   logic [31:0] chksum;

   boot_loader #(.IMEM_LENGTH(Imem), .DMEM_LENGTH(Dmem)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .restart(restart),
      .i_csb(i_csb), .i_web(i_web), .i_addr(i_addr), .i_din(i_din),
      .d_csb(d_csb), .d_web(d_web), .d_addr(d_addr), .d_din(d_din),
      .instr_csb0(instr_csb0), .instr_web0(instr_web0),
      .instr_addr0(instr_addr0), .instr_din0(instr_din0),
      .data_csb0(data_csb0), .data_web0(data_web0),
      .data_addr0(data_addr0), .data_din0(data_din0),
      .core_RSTn(core_RSTn), .done(done), .chksum(chksum)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Shadow SRAMs capture whatever the DUT writes.
   logic [31:0] tb_imem [1024];
   logic [31:0] tb_dmem [1024];
   always @(posedge CLK) begin
      if (!instr_csb0 && !instr_web0) tb_imem[instr_addr0] <= instr_din0;
      if (!data_csb0 && !data_web0) tb_dmem[data_addr0] <= data_din0;
   end

   // Reference model: words accepted so far in this load, their sum, and whether
   // the first edge after reset has passed.
   int unsigned n;
   logic [31:0] sum;
   logic        live;
   logic [31:0] exp_imem [Imem];
   logic [31:0] exp_dmem [Dmem];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic rs);
      logic fin, in_i, acc;
      src_valid = v;
      src_data  = d;
      restart   = rs;
      i_csb  = 1'($urandom); i_web = 1'($urandom); i_addr = 10'($urandom); i_din = $urandom;
      d_csb  = 1'($urandom); d_web = 1'($urandom); d_addr = 10'($urandom); d_din = $urandom;
      #2;
      fin  = (n == Total);
      in_i = (n < Imem);
      acc  = v && live && !fin;
      check("src_ready", 32'(src_ready), 32'(live && !fin));
      check("done", 32'(done), 32'(fin));
      check("core_RSTn", 32'(core_RSTn), 32'(fin));
      check("chksum", chksum, sum);
      if (fin) begin
         check("pass_instr", {instr_csb0, instr_web0, instr_addr0, instr_din0},
               {i_csb, i_web, i_addr, i_din});
         check("pass_data", {data_csb0, data_web0, data_addr0, data_din0},
               {d_csb, d_web, d_addr, d_din});
      end else begin
         check("instr_csb0", 32'(instr_csb0), 32'(!(acc && in_i)));
         check("data_csb0", 32'(data_csb0), 32'(!(acc && !in_i)));
         if (acc && in_i) begin
            check("instr_web0", 32'(instr_web0), 32'd0);
            check("instr_addr0", 32'(instr_addr0), n);
            check("instr_din0", instr_din0, d);
         end
         if (acc && !in_i) begin
            check("data_web0", 32'(data_web0), 32'd0);
            check("data_addr0", 32'(data_addr0), n - Imem);
            check("data_din0", data_din0, d);
         end
      end
      @(posedge CLK);
      live = 1'b1;
      if (acc) begin
         if (in_i) exp_imem[n] = d;
         else exp_dmem[n - Imem] = d;
         sum = sum + d;
         n++;
      end else if (fin && rs) begin
         n   = 0;
         sum = '0;
      end
      #1;
   endtask

   task automatic do_reset();
      src_valid = 1'b0;
      restart   = 1'b0;
      RSTn      = 1'b0;
      #1;
      check("rst_src_ready", 32'(src_ready), 32'd0);
      check("rst_instr_csb0", 32'(instr_csb0), 32'd1);
      check("rst_data_csb0", 32'(data_csb0), 32'd1);
      check("rst_core_RSTn", 32'(core_RSTn), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_chksum", chksum, 32'd0);
      n    = 0;
      sum  = '0;
      live = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic run_load(input int unsigned max_steps);
      int unsigned k;
      k = 0;
      while (n != Total && k < max_steps) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom));
         k++;
      end
      check("load_timeout", n, Total);
   endtask

   task automatic check_mems();
      for (int i = 0; i < Imem; i++) check("imem", tb_imem[i], exp_imem[i]);
      for (int i = 0; i < Dmem; i++) check("dmem", tb_dmem[i], exp_dmem[i]);
   endtask

   initial begin
      RSTn = 1'b0;
      src_valid = 1'b0; src_data = '0; restart = 1'b0;
      i_csb = 1'b1; i_web = 1'b1; i_addr = '0; i_din = '0;
      d_csb = 1'b1; d_web = 1'b1; d_addr = '0; d_din = '0;
      #3;
      do_reset();

      // Back-to-back load of words 1..91.
      for (int k = 0; k < 92; k++) begin
         step(1'b1, n + 1, 1'b0);
         if (k == 90) check("core_RSTn_edge91", 32'(core_RSTn), 32'd0);
      end
      check("core_RSTn_edge92", 32'(core_RSTn), 32'd1);
      check("chksum_b2b", chksum, 32'd4186);
      check_mems();
      for (int k = 0; k < 4; k++) step(1'b1, $urandom, 1'b0);

      // Restart, then a gapped start with 0xA, 0xB.
      step(1'b0, '0, 1'b1);
      check("restart_core_RSTn", 32'(core_RSTn), 32'd0);
      check("restart_done", 32'(done), 32'd0);
      step(1'b1, 32'hA, 1'b0);
      step(1'b0, $urandom, 1'b0);
      step(1'b1, 32'hB, 1'b0);
      step(1'b0, $urandom, 1'b0);
      check("gap_count", n, 32'd2);
      run_load(2000);
      check("reload_core_RSTn", 32'(core_RSTn), 32'd1);
      check_mems();
      for (int k = 0; k < 6; k++) step(1'($urandom), $urandom, 1'b0);

      // Reset mid-load after 40 words, then a fresh random load.
      step(1'b0, '0, 1'b1);
      for (int k = 0; k < 400 && n < 40; k++) step(1'($urandom), $urandom, 1'b0);
      check("midload_count", n, 32'd40);
      do_reset();
      run_load(2000);
      check("chksum_after_reset", chksum, sum);
      check_mems();
      for (int k = 0; k < 6; k++) step(1'($urandom), $urandom, 1'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
